uart_tx_buffered: RTL and testbench

- Byte-level UART transmitter (8N1, LSB first) with an internal FIFO; sits directly downstream of the info/ASCII formatters and drives the board TX pin.
- Accepts bytes through the existing txStart/txData/txBusy handshake, so upstream producers push strings without waiting for each frame to finish.
- Serializes queued bytes back-to-back at the configured baud rate.

---
 rtl/uart_tx_buffered_if.sv | 35 +++
 rtl/uart_tx_buffered.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte-push handshake and status bundle between a producer and uart_tx_buffered.
// master = producer side, slave = transmitter side.
interface uart_tx_buffered_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic          txStart;
    logic [7:0]    txData;
    logic          tx;
    logic          txBusy;
    logic          txIdle;
    logic [AW:0]   fifoCount;
    logic          overflow;

    modport master (
        output txStart,
        output txData,
        input  tx,
        input  txBusy,
        input  txIdle,
        input  fifoCount,
        input  overflow
    );

    modport slave (
        input  txStart,
        input  txData,
        output tx,
        output txBusy,
        output txIdle,
        output fifoCount,
        output overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first; push-to-start-bit latency 2 clocks, frames back-to-back.
// Backpressure: txBusy high after each push until txStart drops, and held while the FIFO is full.
module uart_tx_buffered #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              uartTxRstN,
    uart_tx_buffered_if.slave bus
);
    localparam int unsigned DIV = CLK_FREQ / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q,    state_d;
    logic [BW-1:0]   baud_q,     baud_d;
    logic [2:0]      bit_idx_q,  bit_idx_d;
    logic [7:0]      shift_q,    shift_d;
    logic            tx_q,       tx_d;
    logic            start_q,    start_d;
    logic            ack_pend_q, ack_pend_d;
    logic            busy_q,     busy_d;
    logic            idle_q,     idle_d;
    logic            ovf_q,      ovf_d;
    logic [AW:0]     count_q,    count_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            push;
    logic            accept;
    logic            pop;
    logic            bit_done;
    logic            fifo_empty;

    assign push       = bus.txStart && !start_q;
    assign bit_done   = (baud_q == BAUD_LAST);
    assign fifo_empty = (count_q == '0);

    // Serializer: each state holds for exactly DIV clocks; STOP may chain straight into START.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A same-cycle pop frees a slot, so a push at full is still accepted then.
    always_comb begin
        start_d    = bus.txStart;
        accept     = push && ((count_q != FULL_CNT) || pop);
        ovf_d      = ovf_q || (push && !accept);
        wr_ptr_d   = accept ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop    ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(accept) - (AW+1)'(pop);
        ack_pend_d = ack_pend_q;
        if (push) begin
            ack_pend_d = 1'b1;
        end else if (!bus.txStart) begin
            ack_pend_d = 1'b0;
        end
        busy_d = ack_pend_d || (count_d == FULL_CNT);
        idle_d = (count_d == '0) && (state_d == S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge uartTxRstN) begin
        if (!uartTxRstN) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            start_q    <= 1'b0;
            ack_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b1;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            start_q    <= start_d;
            ack_pend_q <= ack_pend_d;
            busy_q     <= busy_d;
            idle_q     <= idle_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= bus.txData;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.txBusy    = busy_q;
    assign bus.txIdle    = idle_q;
    assign bus.fifoCount = count_q;
    assign bus.overflow  = ovf_q;

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!uartTxRstN) pop |-> !fifo_empty);
    a_count_range:  assert property (@(posedge clk) disable iff (!uartTxRstN) count_q <= FULL_CNT);
    a_ptr_match:    assert property (@(posedge clk) disable iff (!uartTxRstN)
                                     (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized bench for uart_tx_buffered: a line monitor decodes every frame and scores it against a byte queue.
module tb_uart_tx_buffered;
    localparam int unsigned DEPTH = 16;
    localparam int FRAME = 160;
    localparam int BITC  = 16;

    logic clk;
    logic uartTxRstN;
    int   cyc;
    int   tests_run;
    int   tests_failed;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(
        .CLK_FREQ   (160),
        .BAUD       (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .uartTxRstN (uartTxRstN),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: bytes accepted in order, and the bit pattern each frame must show.
    logic [7:0] exp_q [$];
    int         starts [$];
    int         frames_started;
    int         frames_done;
    bit         mon_en;
    bit         mon_busy;
    int         peak;

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (int'(bus.fifoCount) > peak) peak = int'(bus.fifoCount);
    end

    logic [7:0] m_got;
    logic [7:0] m_exp;
    logic       m_bit;
    int         m_bad;
    bit         m_have;
    bit         m_abort;

    initial begin
        frames_started = 0;
        frames_done    = 0;
        mon_busy       = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && bus.tx === 1'b0) begin
                mon_busy = 1'b1;
                frames_started++;
                starts.push_back(cyc);
                m_have  = (exp_q.size() > 0);
                m_exp   = m_have ? exp_q.pop_front() : 8'h00;
                m_bad   = 0;
                m_got   = 8'h00;
                m_abort = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!mon_en) begin
                        m_abort = 1'b1;
                        break;
                    end
                    if (k / BITC == 0)      m_bit = 1'b0;
                    else if (k / BITC == 9) m_bit = 1'b1;
                    else                    m_bit = m_exp[k / BITC - 1];
                    if (bus.tx !== m_bit) m_bad++;
                    if ((k % BITC) == 8 && (k / BITC) >= 1 && (k / BITC) <= 8)
                        m_got[k / BITC - 1] = bus.tx;
                end
                if (!m_abort) begin
                    check_val("frame_expected", int'(m_have), 1);
                    check_val("frame_byte", int'(m_got), int'(m_exp));
                    check_val("frame_bit_timing", m_bad, 0);
                    frames_done++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    // Handshake push: wait for txBusy low, pulse txStart for one cycle.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.txBusy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val("busy_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.txStart = 1'b1;
        bus.txData  = b;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        bus.txStart = 1'b0;
        bus.txData  = 8'($urandom);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || mon_busy) && n < limit);
        if (n >= limit) check_val("drain_timeout", 1, 0);
    endtask

    int base;
    int lows;
    int bad;
    int n;
    int start_c;
    logic [7:0] str_b [6];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        peak         = 0;
        mon_en       = 1'b0;
        uartTxRstN   = 1'b0;
        bus.txStart  = 1'b0;
        bus.txData   = 8'h00;
        str_b = '{8'h31, 8'h2A, 8'h32, 8'h2A, 8'h33, 8'h20};

        // Reset state and a quiet line
        repeat (3) @(negedge clk);
        #2 uartTxRstN = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_val("rst_tx", int'(bus.tx), 1);
        check_val("rst_busy", int'(bus.txBusy), 0);
        check_val("rst_idle", int'(bus.txIdle), 1);
        check_val("rst_count", int'(bus.fifoCount), 0);
        check_val("rst_ovf", int'(bus.overflow), 0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        check_val("quiet_line", lows, 0);

        // Single byte 0x41: busy timing, 2-cycle latency, idle afterwards
        base = frames_done;
        @(posedge clk);
        #1;
        bus.txStart = 1'b1;
        bus.txData  = 8'h41;
        exp_q.push_back(8'h41);
        @(posedge clk);
        #1;
        bus.txStart = 1'b0;
        @(negedge clk);
        check_val("a41_busy_after_edge", int'(bus.txBusy), 1);
        check_val("a41_idle_fell", int'(bus.txIdle), 0);
        check_val("a41_tx_still_high", int'(bus.tx), 1);
        @(negedge clk);
        check_val("a41_tx_start_bit", int'(bus.tx), 0);
        check_val("a41_busy_cleared", int'(bus.txBusy), 0);
        wait_drain(400);
        @(negedge clk);
        check_val("a41_idle_after", int'(bus.txIdle), 1);
        check_val("a41_frames", frames_done - base, 1);

        // "1*2*3 " back to back
        starts.delete();
        peak = 0;
        base = frames_done;
        for (int i = 0; i < 6; i++) push_byte(str_b[i]);
        wait_drain(1500);
        check_val("str_frames", frames_done - base, 6);
        check_val("str_starts", starts.size(), 6);
        if (starts.size() == 6) begin
            for (int i = 1; i < 6; i++) check_val("str_contiguous", starts[i] - starts[i-1], FRAME);
        end
        check_val("str_peak_ge4", int'(peak >= 4), 1);
        check_val("str_count_end", int'(bus.fifoCount), 0);

        // Fill to full during the first frame, then force one push while full
        base = frames_done;
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
        @(negedge clk);
        check_val("full_count", int'(bus.fifoCount), DEPTH);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.txBusy !== 1'b1) bad++;
        end
        check_val("full_busy_held", bad, 0);
        check_val("full_ovf_before", int'(bus.overflow), 0);
        @(posedge clk);
        #1;
        bus.txStart = 1'b1;
        bus.txData  = 8'hEE;
        @(posedge clk);
        #1;
        bus.txStart = 1'b0;
        @(negedge clk);
        check_val("full_ovf_set", int'(bus.overflow), 1);
        check_val("full_count_kept", int'(bus.fifoCount), DEPTH);
        wait_drain(4000);
        repeat (200) @(negedge clk);
        check_val("full_frames", frames_done - base, DEPTH + 1);
        check_val("full_ovf_sticky", int'(bus.overflow), 1);

        // txStart held high for 50 cycles
        base = frames_done;
        @(posedge clk);
        #1;
        bus.txStart = 1'b1;
        bus.txData  = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        bad = 0;
        repeat (49) begin
            @(negedge clk);
            if (bus.txBusy !== 1'b1) bad++;
        end
        check_val("hold_busy_high", bad, 0);
        @(posedge clk);
        #1;
        bus.txStart = 1'b0;
        @(negedge clk);
        check_val("hold_busy_until_sampled", int'(bus.txBusy), 1);
        @(negedge clk);
        check_val("hold_busy_clear", int'(bus.txBusy), 0);
        wait_drain(400);
        repeat (200) @(negedge clk);
        check_val("hold_one_frame", frames_done - base, 1);

        // Asynchronous reset during data bit 3
        base = frames_started;
        push_byte(8'hA5);
        push_byte(8'h3C);
        n = 0;
        while (frames_started == base && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("rst_frame_began", int'(frames_started != base), 1);
        start_c = (starts.size() > 0) ? starts[starts.size()-1] : cyc;
        n = 0;
        while (cyc < start_c + 70 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("pre_rst_count", int'(bus.fifoCount), 1);
        #2;
        mon_en     = 1'b0;
        uartTxRstN = 1'b0;
        #1;
        check_val("async_rst_tx", int'(bus.tx), 1);
        check_val("async_rst_count", int'(bus.fifoCount), 0);
        check_val("async_rst_ovf", int'(bus.overflow), 0);
        check_val("async_rst_idle", int'(bus.txIdle), 1);
        repeat (3) @(negedge clk);
        #2 uartTxRstN = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        base = frames_started;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        check_val("post_rst_quiet", lows, 0);
        check_val("post_rst_no_frame", frames_started - base, 0);

        // Random bursts with random spacing
        base = frames_done;
        n = 0;
        for (int b = 0; b < 4; b++) begin
            int len;
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                push_byte(8'($urandom));
                n++;
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_drain(8000);
        @(negedge clk);
        check_val("rand_frames", frames_done - base, n);
        check_val("rand_ovf", int'(bus.overflow), 0);
        check_val("rand_count", int'(bus.fifoCount), 0);
        check_val("rand_idle", int'(bus.txIdle), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
